// File: rtl/mem_dump_tx_pkg.sv
// mem_dump_tx_pkg: UART framing constants, sequencer states and word sizing shared by the dump transmitter.
package mem_dump_tx_pkg;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int FRAME_BITS = 10;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   typedef enum logic [2:0] {IDLE, SYNC, FETCH, LOAD, WAIT_TX} state_t;
   function automatic int word_width(input int opcode_width, input int register_width);
      return opcode_width + register_width;
   endfunction
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serializer; busy_o drops in the last stop-bit cycle so a new frame can follow seamlessly.
module uart_tx_core
   import mem_dump_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [7:0] data_i,
   output logic       busy_o,
   output logic       tx_o
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic tx_q, tx_d, active_q, active_d, bit_end;
   always_comb begin
      bit_end = active_q && baud_q == BAUD_LAST;
      busy_o = active_q && !(bit_end && bit_q == BIT_LAST);
      baud_d = baud_q;
      bit_d = bit_q;
      shift_d = shift_q;
      tx_d = tx_q;
      active_d = active_q;
      if (start_i && !busy_o) begin
         active_d = 1'b1;
         tx_d = START_BIT;
         shift_d = data_i;
         baud_d = '0;
         bit_d = '0;
      end else if (bit_end) begin
         // Stop bits shift in from the top, so the ninth bit out is the stop bit.
         baud_d = '0;
         bit_d = bit_q + 1'b1;
         tx_d = shift_q[0];
         shift_d = {STOP_BIT, shift_q[7:1]};
         if (bit_q == BIT_LAST) begin
            active_d = 1'b0;
            tx_d = STOP_BIT;
            bit_d = '0;
         end
      end else if (active_q) begin
         baud_d = baud_q + 1'b1;
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         baud_q <= '0;
         bit_q <= '0;
         shift_q <= '0;
         tx_q <= STOP_BIT;
         active_q <= 1'b0;
      end else begin
         baud_q <= baud_d;
         bit_q <= bit_d;
         shift_q <= shift_d;
         tx_q <= tx_d;
         active_q <= active_d;
      end
   end
   assign tx_o = tx_q;
endmodule

// File: rtl/mem_dump_tx.sv
// mem_dump_tx: sends a sync byte then every program-memory word as 8N1 UART frames.
module mem_dump_tx
   import mem_dump_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int OPERATION_CODE_WIDTH = 3,
   parameter int REGISTER_WIDTH = 4,
   parameter int MEMORY_ADDRESS_WIDTH = 4,
   parameter int MEMORY_REGISTERS = 16,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
   localparam int WORD_WIDTH = word_width(OPERATION_CODE_WIDTH, REGISTER_WIDTH)
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            dump_start_i,
   input  logic [WORD_WIDTH-1:0]           mem_data_i,
   output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            tx_o
);
   localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_LAST = MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
   state_t state_q, state_d;
   logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic done_q, done_d, tx_start, core_busy;
   logic [7:0] tx_data;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      done_d = 1'b0;
      tx_start = 1'b0;
      tx_data = SYNC_BYTE;
      case (state_q)
         IDLE: begin
            addr_d = '0;
            if (dump_start_i) begin
               tx_start = 1'b1;
               state_d = SYNC;
            end
         end
         SYNC: state_d = core_busy ? SYNC : FETCH;
         FETCH: state_d = LOAD;
         LOAD: begin
            tx_start = 1'b1;
            tx_data = 8'(mem_data_i);
            state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (!core_busy) begin
               state_d = (addr_q == ADDR_LAST) ? IDLE : FETCH;
               done_d = addr_q == ADDR_LAST;
               addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            addr_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         addr_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         done_q <= done_d;
      end
   end
   uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .start_i(tx_start),
      .data_i(tx_data),
      .busy_o(core_busy),
      .tx_o(tx_o)
   );
   assign mem_addr_o = addr_q;
   assign busy_o = state_q != IDLE;
   assign done_o = done_q;
endmodule
